s_mem_arbiter: RTL and testbench
================================

# s_mem_arbiter

Round-robin arbiter that shares the single-port S memory (256 x 8) between the RC4 phase engines: index fill, key shuffle, second shuffle, and S reader. It replaces the state-keyed mux in the top level. Each engine raises a request and drives its own address, data and write-enable. The arbiter grants exactly one engine at a time, routes that engine's signals to the memory, tags returning read data to the owner, and enforces a hold-time watchdog.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (index 0 = fill, 1 = shuffle, 2 = second shuffle, 3 = S reader).
- ADDR_W, 8, S memory address width.
- DATA_W, 8, S memory data width.
- MAX_HOLD, 0, maximum consecutive GRANT cycles per grant; 0 disables the watchdog.

Ports:
- CLOCK_50  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; level, held for the whole transaction.
- addr_in  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- data_in  in  NUM_REQ*DATA_W  packed write data, same packing as addr_in.
- wren_in  in  NUM_REQ  per-requester write enable.
- grant  out  NUM_REQ  registered one-hot grant.
- busy  out  1  high in GRANT or DRAIN.
- mem_address  out  ADDR_W  to s_memory address.
- mem_data  out  DATA_W  to s_memory data.
- mem_wren  out  1  to s_memory wren.
- q_valid  out  NUM_REQ  registered one-hot; bit i set means the memory q this cycle answers requester i's read from the previous cycle.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT, DRAIN.
- Internal registers: state, grant, last (index of the last grantee), hold_cnt, blocked[NUM_REQ], q_valid, timeout.
- IDLE:
  - Eligible requesters are req & ~blocked.
  - If any requester is eligible, pick the first one found cyclically starting at last+1 (mod NUM_REQ).
  - Set grant to that one-hot value, set last to its index, clear hold_cnt, and go to GRANT.
- GRANT:
  - mem_* are driven combinationally from the grantee's slice; mem_wren = wren_in[g].
  - hold_cnt increments each cycle and saturates.
  - If req[g] is low, clear grant and go to DRAIN.
  - Else, if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: clear grant, set blocked[g], pulse timeout, and go to DRAIN.
- DRAIN: one cycle with mem_wren = 0 and mem_address/mem_data = 0. Then go to IDLE.
- Outside GRANT, every mem_* output is 0.
- blocked[i] clears on any cycle where req[i] is low. A revoked requester must drop req before it is eligible again.
- q_valid next-state = grant & {NUM_REQ{state==GRANT & ~mem_wren}}. A read issued in the final GRANT cycle is therefore tagged during DRAIN.
- The arbiter has no write buffering and no data storage. Requester inputs outside the granted slice are ignored.

## Timing
- Reset values:
  - state = IDLE, grant = 0, last = NUM_REQ-1 (requester 0 wins the first contention).
  - hold_cnt = 0, blocked = 0, q_valid = 0, timeout = 0, busy = 0.
  - mem_* = 0.
- Asserting reset clears grant and forces mem_wren low immediately, including mid-transaction. No write completes after the reset edge.
- Request-to-grant latency: req high in IDLE at edge t gives grant high after edge t (one cycle). A requester's first memory cycle is the first cycle grant[i] is seen high.
- Release-to-next-grant: req[g] sampled low at edge t → DRAIN after t → IDLE after t+1 → new grant after t+2. The minimum gap between grants is 2 cycles with mem_wren = 0.
- Read latency: address presented in cycle n; q and q_valid[g] are both valid in cycle n+1.
- Simultaneous events:
  - req[g] dropping on the same edge the watchdog fires counts as a normal release: no timeout pulse, blocked not set.
  - A new req from another requester during GRANT or DRAIN waits for IDLE; no preemption.
- Requests seen only in GRANT/DRAIN and then withdrawn are never granted. Grants are never issued in DRAIN.

## Test plan
- Reset, then req = 4'b0001 held 256 cycles with wren high and addr incrementing → grant = 0001 one cycle after req; mem_address tracks addr_in[7:0]; grant clears 1 cycle after req drops.
- req = 4'b1111 from IDLE after reset, each requester dropping req after 3 GRANT cycles → grant order 0001, 0010, 0100, 1000, 0001, with a 2-cycle mem_wren = 0 gap between grants.
- Requester 3 reads addr 0x05 from memory holding 0x5A → q = 0x5A and q_valid = 1000 in the following cycle; q_valid = 0 during write cycles.
- MAX_HOLD = 4, req[1] held high → exactly 4 GRANT cycles, timeout pulses once, then DRAIN. req[1] is not re-granted until it goes low for at least one cycle; req[2] raised meanwhile is granted next.
- Reset asserted mid-write (wren_in[1] = 1, granted) → mem_wren and grant fall within the same cycle. After release, state = IDLE and the next req[0] is granted in one cycle.
- Requester 2 drives wren_in[2] = 1 while requester 0 holds the grant → mem_wren follows only wren_in[0]; memory contents at requester 2's address are unchanged.

Source files
------------

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter
// Round-robin owner selection for the shared single-port RC4 S memory.
// One engine owns the memory at a time. The owner's address, data and write
// enable reach the memory combinationally. Returning read data is tagged one
// cycle later through q_valid. An optional watchdog revokes an overlong grant.
module s_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic [NUM_REQ-1:0]        wren_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    output logic [NUM_REQ-1:0]        q_valid,
    output logic                      timeout
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Requester 0 wins the first contention because the search starts at last+1.
    localparam logic [IDX_W-1:0]  LAST_RST     = IDX_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT     = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LIMIT   = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    logic [1:0]         state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [IDX_W-1:0]   last_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [NUM_REQ-1:0] blocked_r;
    logic [NUM_REQ-1:0] q_valid_r;
    logic               timeout_r;

    logic [1:0]         state_n_s;
    logic [NUM_REQ-1:0] grant_n_s;
    logic [IDX_W-1:0]   last_n_s;
    logic [HOLD_W-1:0]  hold_n_s;
    logic [NUM_REQ-1:0] blocked_n_s;
    logic [NUM_REQ-1:0] q_valid_n_s;
    logic               timeout_n_s;

    logic [NUM_REQ-1:0] eligible_s;
    logic [IDX_W:0]     pick_s;
    logic               in_grant_s;

    // Cyclic search starting just after 'last'; MSB flags that a winner exists.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] result;
        int             idx;
        result = {(IDX_W + 1){1'b0}};
        // Walk from farthest to nearest so the nearest eligible entry wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (elig[IDX_W'(idx)]) begin
                result = {1'b1, IDX_W'(idx)};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = {NUM_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Route the owner's slice to the memory; everything is zero outside GRANT.
    always_comb begin
        in_grant_s = (state_r == ST_GRANT);
        if (in_grant_s) begin
            mem_address = addr_in[last_r*ADDR_W +: ADDR_W];
            mem_data    = data_in[last_r*DATA_W +: DATA_W];
            mem_wren    = wren_in[last_r];
        end else begin
            mem_address = {ADDR_W{1'b0}};
            mem_data    = {DATA_W{1'b0}};
            mem_wren    = 1'b0;
        end
    end

    // Arbitration, hold watchdog and read tagging for the next cycle.
    always_comb begin
        eligible_s  = req & ~blocked_r;
        pick_s      = rr_pick(eligible_s, last_r);
        state_n_s   = state_r;
        grant_n_s   = grant_r;
        last_n_s    = last_r;
        hold_n_s    = hold_cnt_r;
        // A revoked requester becomes eligible again once it drops req.
        blocked_n_s = blocked_r & req;
        timeout_n_s = 1'b0;
        q_valid_n_s = grant_r & {NUM_REQ{in_grant_s & ~mem_wren}};
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_n_s = ST_GRANT;
                    grant_n_s = onehot(pick_s[IDX_W-1:0]);
                    last_n_s  = pick_s[IDX_W-1:0];
                    hold_n_s  = {HOLD_W{1'b0}};
                end else begin
                    grant_n_s = {NUM_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                if (hold_cnt_r != HOLD_SAT) begin
                    hold_n_s = hold_cnt_r + HOLD_W'(1);
                end else begin
                    hold_n_s = hold_cnt_r;
                end
                // A release on the watchdog edge is a normal release.
                if (!req[last_r]) begin
                    state_n_s = ST_DRAIN;
                    grant_n_s = {NUM_REQ{1'b0}};
                end else if ((MAX_HOLD != 0) && (hold_cnt_r == HOLD_LIMIT)) begin
                    state_n_s           = ST_DRAIN;
                    grant_n_s           = {NUM_REQ{1'b0}};
                    blocked_n_s[last_r] = 1'b1;
                    timeout_n_s         = 1'b1;
                end else begin
                    state_n_s = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                state_n_s = ST_IDLE;
                grant_n_s = {NUM_REQ{1'b0}};
            end
            default: begin
                state_n_s = ST_IDLE;
                grant_n_s = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers; reset drops the grant (and so mem_wren) at once.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            last_r     <= LAST_RST;
            hold_cnt_r <= {HOLD_W{1'b0}};
            blocked_r  <= {NUM_REQ{1'b0}};
            q_valid_r  <= {NUM_REQ{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            grant_r    <= grant_n_s;
            last_r     <= last_n_s;
            hold_cnt_r <= hold_n_s;
            blocked_r  <= blocked_n_s;
            q_valid_r  <= q_valid_n_s;
            timeout_r  <= timeout_n_s;
        end
    end

    assign grant   = grant_r;
    assign busy    = (state_r == ST_GRANT) || (state_r == ST_DRAIN);
    assign q_valid = q_valid_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Randomized bench for s_mem_arbiter with a transaction-level reference model.
// Four requester agents raise req, do a random number of memory cycles, and
// release. A small synchronous RAM stands in for s_memory. Expected read data
// and timeout pulses are queued at the clock edge and popped by a monitor.
module tb_s_mem_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 5;
    localparam int N_CYC    = 4000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  wren_in;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [3:0]  q_valid;
    logic        timeout;

    s_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (req),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .wren_in    (wren_in),
        .grant      (grant),
        .busy       (busy),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .q_valid    (q_valid),
        .timeout    (timeout)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] init_val(input int a);
        if (a == 5) return 8'h5A;
        return 8'(a * 37 + 11);
    endfunction

    // Stand-in for s_memory: synchronous write, registered read.
    logic [7:0] ram [256];
    logic [7:0] q;
    logic       ram_load;
    always @(posedge CLOCK_50) begin
        if (ram_load) begin
            for (int a = 0; a < 256; a++) ram[a] <= init_val(a);
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        q <= ram[mem_address];
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    typedef struct {
        logic [3:0] who;
        logic [7:0] data;
    } rd_t;

    rd_t rd_q[$];
    int  to_q[$];

    // ---------------- reference model ----------------
    int         m_owner;   // current memory owner, -1 when nobody
    int         m_cool;    // cycles left before the arbiter may choose again
    int         m_rr;      // index of the last owner
    int         m_held;    // memory cycles the owner has had
    bit         m_blk [4]; // revoked and still requesting
    int         edge_no;
    int         exp_to_cnt;
    int         seen_to_cnt;
    logic [7:0] ref_mem [256];
    bit         mon_en;

    // agent state
    int plan [4];
    int cnt  [4];
    bit revoked [4];

    task automatic model_reset();
        m_owner = -1;
        m_cool  = 0;
        m_rr    = NUM_REQ - 1;
        m_held  = 0;
        for (int i = 0; i < 4; i++) m_blk[i] = 1'b0;
    endtask

    // One clock edge as the arbiter's rules describe it, using the inputs sampled there.
    task automatic model_edge();
        int o;
        int idx;
        edge_no++;
        if (m_owner >= 0) begin
            o = m_owner;
            m_held++;
            if (wren_in[o]) begin
                ref_mem[addr_in[o*8 +: 8]] = data_in[o*8 +: 8];
            end else begin
                rd_q.push_back('{who: 4'(1 << o), data: ref_mem[addr_in[o*8 +: 8]]});
            end
            if (!req[o]) begin
                m_owner = -1;
                m_cool  = 2;
            end else if (m_held == MAX_HOLD) begin
                m_blk[o]   = 1'b1;
                revoked[o] = 1'b1;
                to_q.push_back(edge_no);
                exp_to_cnt++;
                m_owner = -1;
                m_cool  = 2;
            end
        end else begin
            if (m_cool > 0) m_cool--;
            if (m_cool == 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (m_rr + k) % NUM_REQ;
                    if (req[idx] && !m_blk[idx]) begin
                        m_owner = idx;
                        m_rr    = idx;
                        m_held  = 0;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) if (!req[i]) m_blk[i] = 1'b0;
    endtask

    // Requester agents: random address/data/wren every cycle, random transaction length.
    task automatic drive_agents();
        for (int i = 0; i < 4; i++) begin
            addr_in[i*8 +: 8] = 8'($urandom_range(0, 15));
            data_in[i*8 +: 8] = 8'($urandom);
            wren_in[i]        = 1'($urandom_range(0, 1));
            if (m_owner == i) begin
                cnt[i]++;
                if (cnt[i] >= plan[i]) req[i] = 1'b0;
            end else if (req[i]) begin
                if (revoked[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else if (cnt[i] == 0 && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end else begin
                revoked[i] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    req[i]  = 1'b1;
                    plan[i] = int'($urandom_range(1, 8));
                    cnt[i]  = 0;
                end
            end
        end
    endtask

    // Monitor: per-cycle bus comparison plus queued read and timeout events.
    always @(negedge CLOCK_50) begin
        logic [16:0] exp_bus;
        logic [3:0]  exp_grant;
        rd_t         r;
        int          e;
        if (mon_en) begin
            exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            if (m_owner >= 0)
                exp_bus = {wren_in[m_owner], addr_in[m_owner*8 +: 8], data_in[m_owner*8 +: 8]};
            else
                exp_bus = 17'd0;
            check("grant", 32'(grant), 32'(exp_grant));
            check("busy", 32'(busy), 32'(m_owner >= 0 || m_cool == 2));
            check("mem_bus", 32'({mem_wren, mem_address, mem_data}), 32'(exp_bus));
            if (q_valid != 4'b0000 || rd_q.size() > 0) begin
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    check("q_valid", 32'(q_valid), 32'(r.who));
                    check("q_data", 32'(q), 32'(r.data));
                end else begin
                    check("q_valid_spurious", 32'(q_valid), 32'd0);
                end
            end
            if (timeout) seen_to_cnt++;
            if (timeout || to_q.size() > 0) begin
                if (to_q.size() > 0) begin
                    e = to_q.pop_front();
                    check("timeout_pulse", 32'(timeout), 32'd1);
                    check("timeout_edge", 32'(edge_no), 32'(e));
                end else begin
                    check("timeout_spurious", 32'(timeout), 32'd0);
                end
            end
        end
    end

    initial begin
        bit rst_done;
        rst_done    = 1'b0;
        reset       = 1'b1;
        req         = 4'b0000;
        addr_in     = 32'd0;
        data_in     = 32'd0;
        wren_in     = 4'b0000;
        mon_en      = 1'b0;
        ram_load    = 1'b1;
        edge_no     = 0;
        exp_to_cnt  = 0;
        seen_to_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            plan[i] = 1; cnt[i] = 0; revoked[i] = 1'b0;
        end
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        model_reset();

        repeat (3) @(posedge CLOCK_50);
        #1;
        ram_load = 1'b0;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_mem_bus", 32'({mem_wren, mem_address, mem_data}), 32'd0);
        @(negedge CLOCK_50);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge CLOCK_50);
            model_edge();
            #1;
            drive_agents();
            // Reset in the middle of an owner's write cycle.
            if (cyc >= N_CYC / 2 && !rst_done && m_owner >= 0) begin
                wren_in[m_owner] = 1'b1;
                @(negedge CLOCK_50);
                #1;
                check("pre_rst_wren", 32'(mem_wren), 32'd1);
                reset = 1'b1;
                #1;
                check("rst_async_grant", 32'(grant), 32'd0);
                check("rst_async_wren", 32'(mem_wren), 32'd0);
                check("rst_async_busy", 32'(busy), 32'd0);
                model_reset();
                @(posedge CLOCK_50);
                @(negedge CLOCK_50);
                #1;
                reset    = 1'b0;
                rst_done = 1'b1;
            end
        end

        @(negedge CLOCK_50);
        #1;
        check("reset_mid_run_exercised", 32'(rst_done), 32'd1);
        check("pending_reads", 32'(rd_q.size()), 32'd0);
        check("pending_timeouts", 32'(to_q.size()), 32'd0);
        check("timeout_count", 32'(seen_to_cnt), 32'(exp_to_cnt));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
